// File: rtl/mod_pkg.sv
// Shared encodings, widths and step-selection helper for the modulation
// source scheduler and its phase accumulator.
package mod_pkg;

    localparam int PHASE_W  = 8;   // phase accumulator / ROM address width
    localparam int SAMPLE_W = 7;   // unsigned ROM sample width
    localparam int DOUT_W   = 9;   // signed modulating output width
    localparam int SYM_W    = 16;  // symbol length / symbol counter width

    // Modulation modes as presented on cfg_mode.
    typedef enum logic [1:0] {
        MODE_OFF = 2'd0,
        MODE_AM  = 2'd1,
        MODE_ASK = 2'd2,
        MODE_FSK = 2'd3
    } mode_t;

    // Scheduler states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Modes that consume a bit per symbol from the bit stream.
    function automatic logic is_keyed(input mode_t mode);
        logic result;
        result = (mode == MODE_ASK) || (mode == MODE_FSK);
        return result;
    endfunction

    // Phase increment for one clock: FSK with a '1' bit doubles the step
    // (shift left, top bit dropped, i.e. mod 2^PHASE_W); all else uses step.
    function automatic logic [PHASE_W-1:0] active_step(
        input mode_t              mode,
        input logic [PHASE_W-1:0] step,
        input logic               key_bit
    );
        logic [PHASE_W-1:0] result;
        if ((mode == MODE_FSK) && key_bit) begin
            result = {step[PHASE_W-2:0], 1'b0};
        end else begin
            result = step;
        end
        return result;
    endfunction

endpackage

// File: rtl/mod_phase_acc.sv
// Phase accumulator with step selection. The accumulated phase is used
// directly as the address into the external waveform ROM.
module mod_phase_acc
    import mod_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [PHASE_W-1:0] step,
    input  logic               key_bit,
    output logic [PHASE_W-1:0] phase
);

    logic [PHASE_W-1:0] phase_reg;
    logic [PHASE_W-1:0] inc;

    // Select the increment for this clock from mode, step and keying bit.
    always_comb begin
        inc = active_step(mode_t'(mode), step, key_bit);
    end

    // Accumulate modulo 2^PHASE_W; clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= '0;
        end else if (clear) begin
            phase_reg <= '0;
        end else if (enable) begin
            phase_reg <= phase_reg + inc;
        end
    end

    assign phase = phase_reg;

endmodule

// File: rtl/mod_src_sched.sv
// Modulation source scheduler: accepts a configuration, steps a phase
// accumulator through an external waveform ROM, consumes one keying bit per
// symbol (ASK/FSK) and produces a registered modulating sample. A stop request
// is honoured at the next symbol boundary, followed by a two-clock drain.
module mod_src_sched
    import mod_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [1:0]               cfg_mode,
    input  logic [PHASE_W-1:0]       cfg_step,
    input  logic [SYM_W-1:0]         cfg_sym_len,
    input  logic                     stop,
    input  logic                     bit_valid,
    output logic                     bit_ready,
    input  logic                     bit_data,
    output logic [PHASE_W-1:0]       rom_addr,
    input  logic [SAMPLE_W-1:0]      rom_data,
    output logic signed [DOUT_W-1:0] dout,
    output logic                     busy,
    output logic                     underrun
);

    state_t                   state_reg;
    state_t                   state_next;

    // Captured configuration.
    mode_t                    mode_reg;
    logic [PHASE_W-1:0]       step_reg;
    logic [SYM_W-1:0]         len_m1_reg;

    // Symbol tracking.
    logic [SYM_W-1:0]         sym_cnt_reg;
    logic                     cur_bit_reg;
    logic                     stop_pend_reg;
    logic                     drain_cnt_reg;
    logic                     underrun_reg;

    // Alignment pipeline for the ROM read plus output register.
    logic                     vld_d1_reg;
    logic                     key_d1_reg;
    logic signed [DOUT_W-1:0] dout_reg;

    // Decoded per-clock conditions.
    logic                     keyed;
    logic                     boundary;
    logic                     handshake;
    logic                     eff_bit;
    logic                     cfg_accept;
    logic                     run_en;
    logic signed [DOUT_W-1:0] sample_ext;

    // Decode boundary, handshake and the keying bit in effect this clock.
    always_comb begin
        keyed      = is_keyed(mode_reg);
        run_en     = (state_reg == ST_RUN);
        boundary   = run_en && (sym_cnt_reg == len_m1_reg);
        handshake  = run_en && keyed && (sym_cnt_reg == '0);
        // On the handshake clock the incoming bit steers the phase right away;
        // an absent bit counts as 0.
        eff_bit    = handshake ? (bit_valid & bit_data) : cur_bit_reg;
        cfg_accept = (state_reg == ST_IDLE) && cfg_valid
                     && (mode_t'(cfg_mode) != MODE_OFF);
        sample_ext = $signed({{(DOUT_W - SAMPLE_W){1'b0}}, rom_data});
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and state-derived handshake outputs.
    always_comb begin
        state_next = state_reg;
        cfg_ready  = 1'b0;
        busy       = 1'b1;
        bit_ready  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (cfg_accept) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                bit_ready = handshake;
                // A stop arriving on the boundary clock itself also counts.
                if (boundary && (stop || stop_pend_reg)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Capture mode, step and symbol length on an accepted configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg   <= MODE_OFF;
            step_reg   <= '0;
            len_m1_reg <= '0;
        end else if (cfg_accept) begin
            mode_reg   <= mode_t'(cfg_mode);
            step_reg   <= cfg_step;
            // A zero length behaves as one clock per symbol.
            len_m1_reg <= (cfg_sym_len == '0) ? '0 : (cfg_sym_len - 1'b1);
        end
    end

    // Symbol counter: 0..len-1 while running, wrapping at the boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt_reg <= '0;
        end else if (cfg_accept) begin
            sym_cnt_reg <= '0;
        end else if (run_en) begin
            sym_cnt_reg <= boundary ? '0 : (sym_cnt_reg + 1'b1);
        end
    end

    // Latch the keying bit at each handshake and flag a missing bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_bit_reg  <= 1'b0;
            underrun_reg <= 1'b0;
        end else if (cfg_accept) begin
            cur_bit_reg  <= 1'b0;
            underrun_reg <= 1'b0;
        end else if (handshake) begin
            cur_bit_reg <= bit_valid & bit_data;
            if (!bit_valid) begin
                underrun_reg <= 1'b1;
            end
        end
    end

    // Hold a stop request until the boundary; count the two drain clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_pend_reg <= 1'b0;
            drain_cnt_reg <= 1'b0;
        end else begin
            if (cfg_accept || (state_reg == ST_DRAIN)) begin
                stop_pend_reg <= 1'b0;
            end else if (run_en && stop) begin
                stop_pend_reg <= 1'b1;
            end
            drain_cnt_reg <= (state_reg == ST_DRAIN) ? ~drain_cnt_reg : 1'b0;
        end
    end

    // Delay "address issued while running" and the keying bit by one clock so
    // they line up with rom_data, then register the output sample. Loading
    // zero whenever the next state is not RUN keeps dout at 0 in DRAIN/IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_d1_reg <= 1'b0;
            key_d1_reg <= 1'b0;
            dout_reg   <= '0;
        end else begin
            vld_d1_reg <= run_en;
            key_d1_reg <= eff_bit;
            if ((state_next == ST_RUN) && vld_d1_reg) begin
                if ((mode_reg == MODE_ASK) && !key_d1_reg) begin
                    dout_reg <= '0;
                end else begin
                    dout_reg <= sample_ext;
                end
            end else begin
                dout_reg <= '0;
            end
        end
    end

    mod_phase_acc u_phase_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cfg_accept),
        .enable  (run_en),
        .mode    (mode_reg),
        .step    (step_reg),
        .key_bit (eff_bit),
        .phase   (rom_addr)
    );

    assign dout     = dout_reg;
    assign underrun = underrun_reg;

endmodule

// File: tb/tb_mod_src_sched.sv
// Testbench for mod_src_sched: drives configurations, bit streams and stop
// requests, and compares every output against a per-symbol reference model.
module tb_mod_src_sched;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [1:0]        cfg_mode = 2'd0;
    logic [7:0]        cfg_step = 8'd0;
    logic [15:0]       cfg_sym_len = 16'd0;
    logic              stop = 1'b0;
    logic              bit_valid = 1'b0;
    logic              bit_ready;
    logic              bit_data = 1'b0;
    logic [7:0]        rom_addr;
    logic [6:0]        rom_data = 7'd0;
    logic signed [8:0] dout;
    logic              busy;
    logic              underrun;

    int total = 0;
    int bad   = 0;

    // Per-symbol stimulus plan (bit value and whether it is offered).
    int plan_bit   [0:63];
    int plan_valid [0:63];
    int exp_addr   [0:1023];

    always #5 clk = ~clk;

    mod_src_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_mode    (cfg_mode),
        .cfg_step    (cfg_step),
        .cfg_sym_len (cfg_sym_len),
        .stop        (stop),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .bit_data    (bit_data),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .dout        (dout),
        .busy        (busy),
        .underrun    (underrun)
    );

    // Waveform ROM contents: never zero, so keyed-off ASK is distinguishable.
    function automatic logic [6:0] rom_fn(input logic [7:0] a);
        int v;
        v = (int'(a ^ 8'h5A) % 127) + 1;
        return v[6:0];
    endfunction

    // External ROM with one clock of read latency.
    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic plan_fill(input int valid_pct);
        for (int s = 0; s < 64; s++) begin
            plan_bit[s]   = int'($urandom_range(0, 1));
            plan_valid[s] = (int'($urandom_range(0, 99)) < valid_pct) ? 1 : 0;
        end
    endtask

    // Configure, run until the stop drains, and compare every clock. Starts
    // and ends at a falling edge with the DUT idle.
    task automatic run_case(input string name, input int mode, input int step,
                            input int len, input int stop_t);
        int eff_len, drain_at, keyed, s, key, inc, e_dout, e_under;
        logic e_busy, e_br;
        eff_len  = (len == 0) ? 1 : len;
        drain_at = (stop_t / eff_len + 1) * eff_len;
        keyed    = (mode >= 2) ? 1 : 0;
        exp_addr[0] = 0;
        for (int t = 0; t < drain_at; t++) begin
            s   = t / eff_len;
            key = plan_valid[s] ? plan_bit[s] : 0;
            inc = (mode == 3 && key == 1) ? ((step * 2) % 256) : step;
            exp_addr[t + 1] = (exp_addr[t] + inc) % 256;
        end
        cfg_valid   = 1'b1;
        cfg_mode    = 2'(mode);
        cfg_step    = 8'(step);
        cfg_sym_len = 16'(len);
        @(negedge clk);
        for (int t = 0; t <= drain_at + 2; t++) begin
            s         = t / eff_len;
            bit_valid = (t < drain_at && plan_valid[s] == 1);
            bit_data  = plan_valid[s] ? 1'(plan_bit[s]) : 1'($urandom_range(0, 1));
            stop      = (t == stop_t);
            // Offers while busy must be ignored.
            cfg_valid   = (t < drain_at) ? 1'($urandom_range(0, 1)) : 1'b0;
            cfg_mode    = 2'($urandom_range(0, 3));
            cfg_step    = 8'($urandom);
            cfg_sym_len = 16'($urandom_range(0, 9));
            #1;
            e_busy = (t < drain_at + 2);
            e_br   = (t < drain_at) && keyed == 1 && (t % eff_len == 0);
            e_dout = 0;
            if (t < drain_at && t >= 2) begin
                s   = (t - 2) / eff_len;
                key = plan_valid[s] ? plan_bit[s] : 0;
                e_dout = (mode == 2 && key == 0) ? 0 : int'(rom_fn(8'(exp_addr[t - 2])));
            end
            e_under = 0;
            for (int k = 0; k < 64; k++)
                if (keyed == 1 && k * eff_len < t && k * eff_len < drain_at && plan_valid[k] == 0)
                    e_under = 1;
            total++;
            if (busy !== e_busy) begin
                bad++;
                $display("FAIL %s busy t=%0d got=%0b want=%0b", name, t, busy, e_busy);
            end
            total++;
            if (cfg_ready !== !e_busy) begin
                bad++;
                $display("FAIL %s cfg_ready t=%0d got=%0b want=%0b", name, t, cfg_ready, !e_busy);
            end
            total++;
            if (bit_ready !== e_br) begin
                bad++;
                $display("FAIL %s bit_ready t=%0d got=%0b want=%0b", name, t, bit_ready, e_br);
            end
            total++;
            if (dout !== 9'(e_dout)) begin
                bad++;
                $display("FAIL %s dout t=%0d got=%0d want=%0d", name, t, dout, e_dout);
            end
            total++;
            if (underrun !== 1'(e_under)) begin
                bad++;
                $display("FAIL %s underrun t=%0d got=%0b want=%0d", name, t, underrun, e_under);
            end
            if (t < drain_at) begin
                total++;
                if (rom_addr !== 8'(exp_addr[t])) begin
                    bad++;
                    $display("FAIL %s rom_addr t=%0d got=%0d want=%0d", name, t, rom_addr, exp_addr[t]);
                end
            end
            @(negedge clk);
        end
        stop      = 1'b0;
        bit_valid = 1'b0;
        $display("case %s mode=%0d step=%0d len=%0d stop_t=%0d drain_at=%0d", name, mode, step, len, stop_t, drain_at);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || bit_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl got busy=%0b cfg_ready=%0b bit_ready=%0b want 0/1/0", busy, cfg_ready, bit_ready);
        end
        total++;
        if (dout !== 9'd0 || rom_addr !== 8'd0 || underrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_data got dout=%0d rom_addr=%0d underrun=%0b want 0/0/0", dout, rom_addr, underrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("case reset");
    endtask

    task automatic test_cfg_off();
        cfg_valid = 1'b1;
        cfg_mode  = 2'd0;
        cfg_step  = 8'd7;
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL cfg_off got busy=%0b cfg_ready=%0b want 0/1", busy, cfg_ready);
        end
        @(negedge clk);
        $display("case cfg_off");
    endtask

    task automatic test_stop_idle();
        stop = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stop = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || dout !== 9'd0) begin
            bad++;
            $display("FAIL stop_idle got busy=%0b cfg_ready=%0b dout=%0d want 0/1/0", busy, cfg_ready, dout);
        end
        @(negedge clk);
        $display("case stop_idle");
    endtask

    task automatic test_am();
        plan_fill(100);
        run_case("am_step4", 1, 4, 10, 69);
        run_case("am_rand", 1, int'($urandom_range(1, 255)), 3, 20);
    endtask

    task automatic test_ask();
        plan_fill(100);
        plan_bit[0] = 1;
        plan_bit[1] = 0;
        plan_bit[2] = 1;
        run_case("ask_101", 2, 4, 5, 14);
    endtask

    task automatic test_fsk();
        plan_fill(100);
        run_case("fsk_step3", 3, 3, 6, 29);
        plan_bit[0] = 1;
        plan_bit[1] = 1;
        plan_bit[2] = 0;
        run_case("fsk_step90", 3, 8'h90, 4, 9);
    endtask

    task automatic test_underrun();
        plan_fill(100);
        plan_bit[0] = 1;
        plan_bit[1] = 1;
        plan_bit[2] = 1;
        plan_valid[1] = 0;
        run_case("ask_underrun", 2, 5, 5, 14);
        total++;
        if (underrun !== 1'b1) begin
            bad++;
            $display("FAIL underrun_sticky got=%0b want=1", underrun);
        end
        // Next accepted configuration clears the flag (checked from t=0).
        plan_fill(100);
        run_case("ask_clear", 2, 9, 4, 9);
    endtask

    task automatic test_stop();
        plan_fill(100);
        run_case("stop_mid", 2, 6, 8, 11);
        run_case("stop_at_boundary", 2, 6, 8, 7);
        run_case("len_zero", 2, 11, 0, 4);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            plan_fill(80);
            run_case("random", int'($urandom_range(1, 3)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 40)));
        end
    endtask

    task automatic test_async_reset();
        cfg_valid   = 1'b1;
        cfg_mode    = 2'd2;
        cfg_step    = 8'd13;
        cfg_sym_len = 16'd5;
        @(negedge clk);
        cfg_valid = 1'b0;
        bit_valid = 1'b1;
        bit_data  = 1'b1;
        for (int t = 0; t < 5; t++) @(negedge clk);
        #1;
        total++;
        if (bit_ready !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset got bit_ready=%0b busy=%0b want 1/1", bit_ready, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || bit_ready !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_ctl got busy=%0b cfg_ready=%0b bit_ready=%0b want 0/1/0", busy, cfg_ready, bit_ready);
        end
        total++;
        if (dout !== 9'd0 || rom_addr !== 8'd0 || underrun !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_data got dout=%0d rom_addr=%0d underrun=%0b want 0/0/0", dout, rom_addr, underrun);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        bit_valid = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || bit_ready !== 1'b0) begin
            bad++;
            $display("FAIL post_reset got busy=%0b bit_ready=%0b want 0/0", busy, bit_ready);
        end
        @(negedge clk);
        $display("case async_reset");
    endtask

    initial begin
        test_reset();
        test_cfg_off();
        test_stop_idle();
        test_am();
        test_ask();
        test_fsk();
        test_underrun();
        test_stop();
        test_random();
        test_async_reset();
        plan_fill(100);
        run_case("after_reset", 3, 21, 3, 10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_src_sched.md
MOD_SRC_SCHED -- requirements
Module: mod_src_sched

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: cfg_valid  in  1  configuration offer.
REQ-004 SHALL have ports: cfg_ready  out  1  block accepts configuration (IDLE only).
REQ-005 SHALL have ports: cfg_mode  in  2  0=off, 1=AM (continuous), 2=ASK, 3=FSK.
REQ-006 SHALL have ports: cfg_step  in  8  phase step per clk, ROM addresses.
REQ-007 SHALL have ports: cfg_sym_len  in  16  clks per symbol; 0 treated as 1.
REQ-008 SHALL have ports: stop  in  1  request to return to IDLE at next symbol boundary.
REQ-009 SHALL have ports: bit_valid / bit_ready / bit_data  in/out/in  1 each  symbol bit stream, valid-ready handshake.
REQ-010 SHALL have ports: rom_addr  out  8  address to source waveform ROM (1-clk read latency).
REQ-011 SHALL have ports: rom_data  in  7  unsigned ROM sample.
REQ-012 SHALL have ports: dout  out  9 (signed)  modulating sample, {2'b00, sample} or 0.
REQ-013 SHALL have ports: busy  out  1  high when not IDLE; underrun  out  1  sticky underrun flag.

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN; reset state IDLE.
REQ-015 IDLE: cfg_ready=1; cfg_valid&&cfg_mode!=0 captures mode/step/sym_len, clears underrun, zeroes phase and symbol counter, enters RUN next clk; cfg_mode=0 accepted but stays IDLE.
REQ-016 cfg_ready SHALL be 0 in RUN and DRAIN; cfg_valid there ignored.
REQ-017 RUN: phase accumulator (8 bit) SHALL add the active step every clk, wrapping mod 256; rom_addr = phase.
REQ-018 Active step: AM/ASK = cfg_step; FSK = cfg_step when current bit 0, {cfg_step[6:0],1'b0} when 1 (mod 256).
REQ-019 Symbol counter SHALL count 0..sym_len-1; terminal count marks a symbol boundary, counter wraps to 0.
REQ-020 At RUN entry and every boundary in ASK/FSK, bit_ready SHALL pulse high exactly one clk; if bit_valid is high that clk, bit_data is latched as current bit.
REQ-021 If bit_valid low at a boundary: current bit forced 0, underrun set (sticky until next config accept); running continues.
REQ-022 AM mode SHALL never assert bit_ready.
REQ-023 stop in RUN SHALL be latched; at next boundary enter DRAIN (no bit consumed).
REQ-024 DRAIN SHALL last 2 clks (ROM + output pipeline flush, dout forced 0) then IDLE.
REQ-025 dout SHALL be registered, 2 clks after rom_addr: AM -> {2'b00,rom_data}; ASK -> bit? {2'b00,rom_data} : 0; FSK -> {2'b00,rom_data}; IDLE/DRAIN -> 0.
REQ-026 Keying bit used for dout SHALL be delayed to align with the 2-clk ROM/output path.
REQ-027 stop asserted in IDLE SHALL be ignored; stop and boundary in same clk SHALL enter DRAIN that boundary.

Reset
REQ-028 rst_n low SHALL asynchronously force: state IDLE, phase 0, counters 0, dout 0, bit_ready 0, busy 0, underrun 0, cfg_ready 1 after release, rom_addr 0.
REQ-029 Reset mid-RUN SHALL abandon the symbol without consuming a bit; no handshake completes on the reset clk.

Structure
REQ-030 Mode encodings, state encoding and widths (PHASE_W=8, SAMPLE_W=7, DOUT_W=9) SHALL live in a shared package mod_pkg.
REQ-031 The phase accumulator with step select SHALL be one sub-module, mod_phase_acc; ROM remains external.

Verification
REQ-032 AM, step=4, sym_len=10: rom_addr 0,4,8,... wraps 252->0; dout tracks rom_data 2 clks later; bit_ready never high.
REQ-033 ASK, sym_len=5, bits 1,0,1 supplied: bit_ready pulses at clk 0,5,10 of RUN; dout nonzero/zero/nonzero per symbol with 2-clk alignment.
REQ-034 FSK, step=3: bit 0 -> addr increments 3; bit 1 -> increments 6; step=0x90 bit 1 -> increment 0x20.
REQ-035 ASK with bit_valid low at clk 5: underrun=1, dout 0 that symbol; new config accept clears underrun.
REQ-036 stop at mid-symbol, sym_len=8: DRAIN at boundary, dout 0, IDLE 2 clks later, cfg_ready=1.
REQ-037 rst_n low mid-RUN: all outputs to reset values immediately (asynchronous), no bit_ready pulse.
